pp_link_arbiter: RTL and testbench

//  Shares one simulated classical link between the A2B and B2A post-processing message channels of the QKD pair.

---
 rtl/pp_link_pkg.sv | 27 ++
 rtl/pp_link_copy_engine.sv | 102 ++++++++++
 rtl/pp_link_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_pp_link_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_link_pkg.sv
// pp_link_pkg
//   Shared definitions for the post-processing link arbiter: default
//   BRAM geometry, FSM state encoding, direction codes and the
//   round-robin pick helper.
package pp_link_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_COPY = 3'd1,
        ST_DONE = 3'd2,
        ST_GAP  = 3'd3
    } state_t;

    localparam logic DIR_A2B = 1'b0;
    localparam logic DIR_B2A = 1'b1;

    // Pick a direction from a non-zero eligibility vector {b2a, a2b}.
    // With both eligible the direction not served last time wins.
    function automatic logic rr_pick(input logic [1:0] elig, input logic last);
        if (elig == 2'b11) return ~last;
        return elig[1];
    endfunction

endpackage

// File: rtl/pp_link_copy_engine.sv
// pp_link_copy_engine
//   Walks a read address 0..size-1 over the sender TX BRAM, one read every
//   WORD_GAP+1 clocks, and replays each read as a write to the receiver RX
//   BRAM one clock later (the BRAM read latency), at the same address.
// Ports
//   clk, reset_high       clock, synchronous active-high reset
//   start_i               1-cycle pulse: begin a copy of size_i words
//   size_i                message length in words (non-zero)
//   rd_data_i             TX BRAM read data, valid 1 clk after rd_en_o
//   rd_en_o, rd_addr_o    TX BRAM read port
//   wr_en_o, wr_addr_o,
//   wr_data_o             RX BRAM write port
//   wr_last_o             the current write is the final word
module pp_link_copy_engine #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int WORD_GAP = 0
) (
    input  logic              clk,
    input  logic              reset_high,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] size_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              wr_last_o
);

    localparam int GAP_W = (WORD_GAP > 0) ? $clog2(WORD_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_RLD = GAP_W'(WORD_GAP);

    logic              active_q, active_d;   // more reads still to issue
    logic [ADDR_W-1:0] cnt_q, cnt_d;         // next read address
    logic [ADDR_W-1:0] last_q, last_d;       // size-1
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;

    always_comb begin
        active_d  = active_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gap_d     = gap_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        if (start_i) begin
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            cnt_d     = ADDR_W'(1);
            last_d    = size_i - ADDR_W'(1);
            gap_d     = GAP_RLD;
            active_d  = (size_i != ADDR_W'(1));
        end else if (active_q) begin
            if (gap_q != '0) begin
                gap_d = gap_q - GAP_W'(1);
            end else begin
                rd_en_d   = 1'b1;
                rd_addr_d = cnt_q;
                cnt_d     = cnt_q + ADDR_W'(1);
                gap_d     = GAP_RLD;
                if (cnt_q == last_q) active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_high) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            last_q    <= '0;
            gap_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gap_q     <= gap_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= rd_en_q;
            wr_addr_q <= rd_addr_q;
        end
    end

    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    // BRAM output register feeds the write port directly; gated so the
    // data bus reads 0 whenever no write is in flight.
    assign wr_data_o = wr_en_q ? rd_data_i : '0;
    assign wr_last_o = wr_en_q && (wr_addr_q == last_q);

endmodule

// File: rtl/pp_link_arbiter.sv
// pp_link_arbiter
//   Shares one link between the A2B and B2A post-processing message
//   channels. Accepts stored messages, arbitrates round-robin between the
//   eligible directions, copies the message TX BRAM -> peer RX BRAM with
//   a single copy engine, and drives the delivery handshake.
// Ports (per direction {a2b,b2a})
//   busy_PP2Net_TX/RX (in)  sender writing TX / receiver reading RX
//   msg_stored, sizeTX_msg  message-ready pulse and length
//   busy_Net2PP_TX/RX (out) message pending / link writing RX BRAM
//   msg_accessed, sizeRX_msg delivery pulse and held length
//   tx_rd_*, rx_wr_*        BRAM ports driven by the copy engine
// Shared: clk, reset_high, state (debug), err_overrun, err_zero (sticky)
module pp_link_arbiter
    import pp_link_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WORD_GAP = 0
) (
    input  logic              clk,
    input  logic              reset_high,
    input  logic              a2b_busy_PP2Net_TX,
    input  logic              a2b_msg_stored,
    input  logic [ADDR_W-1:0] a2b_sizeTX_msg,
    output logic              a2b_busy_Net2PP_TX,
    input  logic              a2b_busy_PP2Net_RX,
    output logic              a2b_busy_Net2PP_RX,
    output logic              a2b_msg_accessed,
    output logic [ADDR_W-1:0] a2b_sizeRX_msg,
    output logic              a2b_tx_rd_en,
    output logic [ADDR_W-1:0] a2b_tx_rd_addr,
    input  logic [DATA_W-1:0] a2b_tx_rd_data,
    output logic              a2b_rx_wr_en,
    output logic [ADDR_W-1:0] a2b_rx_wr_addr,
    output logic [DATA_W-1:0] a2b_rx_wr_data,
    input  logic              b2a_busy_PP2Net_TX,
    input  logic              b2a_msg_stored,
    input  logic [ADDR_W-1:0] b2a_sizeTX_msg,
    output logic              b2a_busy_Net2PP_TX,
    input  logic              b2a_busy_PP2Net_RX,
    output logic              b2a_busy_Net2PP_RX,
    output logic              b2a_msg_accessed,
    output logic [ADDR_W-1:0] b2a_sizeRX_msg,
    output logic              b2a_tx_rd_en,
    output logic [ADDR_W-1:0] b2a_tx_rd_addr,
    input  logic [DATA_W-1:0] b2a_tx_rd_data,
    output logic              b2a_rx_wr_en,
    output logic [ADDR_W-1:0] b2a_rx_wr_addr,
    output logic [DATA_W-1:0] b2a_rx_wr_data,
    output logic [2:0]        state,
    output logic              err_overrun,
    output logic              err_zero
);

    // Direction-indexed views of the inputs: [0]=A2B, [1]=B2A.
    logic [1:0]             stored, busy_tx_in, busy_rx_in;
    logic [1:0][ADDR_W-1:0] size_in;
    logic [1:0][DATA_W-1:0] rd_data_in;

    assign stored     = {b2a_msg_stored, a2b_msg_stored};
    assign busy_tx_in = {b2a_busy_PP2Net_TX, a2b_busy_PP2Net_TX};
    assign busy_rx_in = {b2a_busy_PP2Net_RX, a2b_busy_PP2Net_RX};
    assign size_in    = {b2a_sizeTX_msg, a2b_sizeTX_msg};
    assign rd_data_in = {b2a_tx_rd_data, a2b_tx_rd_data};

    state_t                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_q, last_d;
    logic [1:0]             pend_q, pend_d;
    logic [1:0]             busy_rx_q, busy_rx_d;
    logic [1:0]             acc_q, acc_d;
    logic [1:0][ADDR_W-1:0] size_q, size_d;
    logic [1:0][ADDR_W-1:0] srx_q, srx_d;
    logic                   eovr_q, eovr_d, ezero_q, ezero_d;

    logic [1:0] elig;
    logic       sel, start;

    logic              eng_rd_en, eng_wr_en, eng_wr_last;
    logic [ADDR_W-1:0] eng_rd_addr, eng_wr_addr;
    logic [DATA_W-1:0] eng_wr_data;

    assign elig = pend_q & ~busy_tx_in & ~busy_rx_in;
    assign sel  = rr_pick(elig, last_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        pend_d    = pend_q;
        busy_rx_d = busy_rx_q;
        acc_d     = 2'b00;
        size_d    = size_q;
        srx_d     = srx_q;
        eovr_d    = eovr_q;
        ezero_d   = ezero_q;
        start     = 1'b0;

        // Accept checks use the registered pending flag, so a pulse on the
        // channel being served (including its last-write cycle) overruns.
        for (int d = 0; d < 2; d++) begin
            if (stored[d]) begin
                if (size_in[d] == '0) begin
                    ezero_d = 1'b1;
                end else if (pend_q[d]) begin
                    eovr_d = 1'b1;
                end else begin
                    pend_d[d] = 1'b1;
                    size_d[d] = size_in[d];
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (elig != 2'b00) begin
                    grant_d = sel;
                    last_d  = sel;
                    start   = 1'b1;
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                // A read now means a write next clock.
                if (eng_rd_en) busy_rx_d[grant_q] = 1'b1;
                if (eng_wr_last) begin
                    busy_rx_d[grant_q] = 1'b0;
                    pend_d[grant_q]    = 1'b0;
                    acc_d[grant_q]     = 1'b1;
                    srx_d[grant_q]     = size_q[grant_q];
                    state_d            = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_high) begin
            state_q   <= ST_IDLE;
            grant_q   <= DIR_A2B;
            last_q    <= DIR_B2A;
            pend_q    <= '0;
            busy_rx_q <= '0;
            acc_q     <= '0;
            size_q    <= '0;
            srx_q     <= '0;
            eovr_q    <= 1'b0;
            ezero_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            busy_rx_q <= busy_rx_d;
            acc_q     <= acc_d;
            size_q    <= size_d;
            srx_q     <= srx_d;
            eovr_q    <= eovr_d;
            ezero_q   <= ezero_d;
        end
    end

    pp_link_copy_engine #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WORD_GAP (WORD_GAP)
    ) u_engine (
        .clk        (clk),
        .reset_high (reset_high),
        .start_i    (start),
        .size_i     (size_q[sel]),
        .rd_data_i  (rd_data_in[grant_q]),
        .rd_en_o    (eng_rd_en),
        .rd_addr_o  (eng_rd_addr),
        .wr_en_o    (eng_wr_en),
        .wr_addr_o  (eng_wr_addr),
        .wr_data_o  (eng_wr_data),
        .wr_last_o  (eng_wr_last)
    );

    // Demux the engine onto the granted direction; the other side stays 0.
    // grant_q only changes on the clock that starts a copy.
    assign a2b_tx_rd_en   = eng_rd_en && (grant_q == DIR_A2B);
    assign a2b_tx_rd_addr = (grant_q == DIR_A2B) ? eng_rd_addr : '0;
    assign a2b_rx_wr_en   = eng_wr_en && (grant_q == DIR_A2B);
    assign a2b_rx_wr_addr = (grant_q == DIR_A2B) ? eng_wr_addr : '0;
    assign a2b_rx_wr_data = (grant_q == DIR_A2B) ? eng_wr_data : '0;
    assign b2a_tx_rd_en   = eng_rd_en && (grant_q == DIR_B2A);
    assign b2a_tx_rd_addr = (grant_q == DIR_B2A) ? eng_rd_addr : '0;
    assign b2a_rx_wr_en   = eng_wr_en && (grant_q == DIR_B2A);
    assign b2a_rx_wr_addr = (grant_q == DIR_B2A) ? eng_wr_addr : '0;
    assign b2a_rx_wr_data = (grant_q == DIR_B2A) ? eng_wr_data : '0;

    assign a2b_busy_Net2PP_TX = pend_q[0];
    assign b2a_busy_Net2PP_TX = pend_q[1];
    assign a2b_busy_Net2PP_RX = busy_rx_q[0];
    assign b2a_busy_Net2PP_RX = busy_rx_q[1];
    assign a2b_msg_accessed   = acc_q[0];
    assign b2a_msg_accessed   = acc_q[1];
    assign a2b_sizeRX_msg     = srx_q[0];
    assign b2a_sizeRX_msg     = srx_q[1];
    assign state              = state_q;
    assign err_overrun        = eovr_q;
    assign err_zero           = ezero_q;

endmodule

// File: tb/tb_pp_link_arbiter.sv
module tb_pp_link_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic          reset_high;
    logic          stored[2];
    logic [AW-1:0] size_tx[2];
    logic          busy_tx_in[2], busy_rx_in[2];

    // [k][d]: k=0 -> WORD_GAP 0 instance, k=1 -> WORD_GAP 2 instance
    logic          bn_tx[2][2], bn_rx[2][2], acc[2][2], rd_en[2][2], wr_en[2][2];
    logic [AW-1:0] size_rx[2][2], rd_addr[2][2], wr_addr[2][2];
    logic [DW-1:0] rd_data[2][2], wr_data[2][2];
    logic [2:0]    st[2];
    logic          eovr[2], ezero[2];

    logic [DW-1:0] txmem[2][2048];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {int cyc; int k; int d; int addr; logic [DW-1:0] data;} wr_t;
    typedef struct {int cyc; int k; int d; int size;} acc_t;
    wr_t  wlog[$];
    acc_t alog[$];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        pp_link_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORD_GAP(2 * k)) u_dut (
            .clk                (clk),
            .reset_high         (reset_high),
            .a2b_busy_PP2Net_TX (busy_tx_in[0]),
            .a2b_msg_stored     (stored[0]),
            .a2b_sizeTX_msg     (size_tx[0]),
            .a2b_busy_Net2PP_TX (bn_tx[k][0]),
            .a2b_busy_PP2Net_RX (busy_rx_in[0]),
            .a2b_busy_Net2PP_RX (bn_rx[k][0]),
            .a2b_msg_accessed   (acc[k][0]),
            .a2b_sizeRX_msg     (size_rx[k][0]),
            .a2b_tx_rd_en       (rd_en[k][0]),
            .a2b_tx_rd_addr     (rd_addr[k][0]),
            .a2b_tx_rd_data     (rd_data[k][0]),
            .a2b_rx_wr_en       (wr_en[k][0]),
            .a2b_rx_wr_addr     (wr_addr[k][0]),
            .a2b_rx_wr_data     (wr_data[k][0]),
            .b2a_busy_PP2Net_TX (busy_tx_in[1]),
            .b2a_msg_stored     (stored[1]),
            .b2a_sizeTX_msg     (size_tx[1]),
            .b2a_busy_Net2PP_TX (bn_tx[k][1]),
            .b2a_busy_PP2Net_RX (busy_rx_in[1]),
            .b2a_busy_Net2PP_RX (bn_rx[k][1]),
            .b2a_msg_accessed   (acc[k][1]),
            .b2a_sizeRX_msg     (size_rx[k][1]),
            .b2a_tx_rd_en       (rd_en[k][1]),
            .b2a_tx_rd_addr     (rd_addr[k][1]),
            .b2a_tx_rd_data     (rd_data[k][1]),
            .b2a_rx_wr_en       (wr_en[k][1]),
            .b2a_rx_wr_addr     (wr_addr[k][1]),
            .b2a_rx_wr_data     (wr_data[k][1]),
            .state              (st[k]),
            .err_overrun        (eovr[k]),
            .err_zero           (ezero[k])
        );
    end

    // TX BRAM model: one clock read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < 2; d++)
                if (rd_en[k][d] === 1'b1) rd_data[k][d] <= txmem[d][rd_addr[k][d]];
    end

    // Event log of RX writes and deliveries, sampled mid-cycle
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < 2; d++) begin
                if (wr_en[k][d] === 1'b1)
                    wlog.push_back('{cyc, k, d, int'(wr_addr[k][d]), wr_data[k][d]});
                if (acc[k][d] === 1'b1)
                    alog.push_back('{cyc, k, d, int'(size_rx[k][d])});
            end
    end

    task automatic step(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset_high = 1'b1;
        stored = '{1'b0, 1'b0};
        size_tx = '{'0, '0};
        busy_tx_in = '{1'b0, 1'b0};
        busy_rx_in = '{1'b0, 1'b0};
        step(2);
        reset_high = 1'b0;
        wlog.delete();
        alog.delete();
    endtask

    task automatic fill(int d, int n);
        for (int i = 0; i < n; i++) txmem[d][i] = $urandom;
    endtask

    task automatic pulse(logic a, logic b, int na, int nb);
        stored[0] = a; stored[1] = b;
        size_tx[0] = AW'(na); size_tx[1] = AW'(nb);
        step();
        stored[0] = 1'b0; stored[1] = 1'b0;
    endtask

    function automatic int n_acc(int k);
        int n;
        n = 0;
        foreach (alog[j]) if (alog[j].k == k) n++;
        return n;
    endfunction

    function automatic acc_t get_acc(int k, int idx);
        acc_t r;
        int seen;
        r = '{-1, -1, -1, -1};
        seen = 0;
        foreach (alog[j]) if (alog[j].k == k) begin
            if (seen == idx) r = alog[j];
            seen++;
        end
        return r;
    endfunction

    // Reference: word i of a delivery lands at addr i, cycle tw0+i*stp,
    // carrying TX word i. Returns the number of deviations.
    function automatic int wr_bad(int k, int d, int n, int tw0, int stp);
        int seen, bad;
        seen = 0; bad = 0;
        foreach (wlog[j]) if (wlog[j].k == k && wlog[j].d == d) begin
            if (wlog[j].addr != seen || wlog[j].cyc != tw0 + seen * stp ||
                wlog[j].data !== txmem[d][seen]) bad++;
            seen++;
        end
        if (seen != n) bad++;
        return bad;
    endfunction

    function automatic logic any_out(int k);
        return bn_tx[k][0] | bn_tx[k][1] | bn_rx[k][0] | bn_rx[k][1] |
               acc[k][0] | acc[k][1] | (|size_rx[k][0]) | (|size_rx[k][1]) |
               rd_en[k][0] | rd_en[k][1] | (|rd_addr[k][0]) | (|rd_addr[k][1]) |
               wr_en[k][0] | wr_en[k][1] | (|wr_addr[k][0]) | (|wr_addr[k][1]) |
               (|wr_data[k][0]) | (|wr_data[k][1]) | (|st[k]) | eovr[k] | ezero[k];
    endfunction

    task automatic wait_acc(int k, int n, int lim);
        for (int c = 0; c < lim && n_acc(k) < n; c++) step();
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (any_out(k) !== 1'b0) begin
                errors++; $display("FAIL reset_outputs inst%0d: got nonzero output, want all 0", k);
            end
        end
    endtask

    task automatic test_single();
        int t, b; acc_t a;
        do_reset(); fill(0, 4);
        t = cyc; pulse(1, 0, 4, 0);
        checks++;
        if (bn_tx[0][0] !== 1'b1) begin
            errors++; $display("FAIL single_busy_tx: got %b want 1", bn_tx[0][0]);
        end
        wait_acc(0, 1, 40);
        checks++;
        if (n_acc(0) !== 1) begin errors++; $display("FAIL single_acc_count: got %0d want 1", n_acc(0)); end
        a = get_acc(0, 0);
        checks++;
        if (a.cyc !== t + 7 || a.d !== 0 || a.size !== 4) begin
            errors++; $display("FAIL single_acc: got cyc %0d d %0d size %0d want cyc %0d d 0 size 4", a.cyc, a.d, a.size, t + 7);
        end
        b = wr_bad(0, 0, 4, t + 3, 1);
        checks++;
        if (b !== 0) begin errors++; $display("FAIL single_writes: got %0d deviations want 0", b); end
        step(3);
        checks++;
        if (size_rx[0][0] !== AW'(4) || bn_tx[0][0] !== 1'b0 || bn_rx[0][0] !== 1'b0) begin
            errors++; $display("FAIL single_hold: got size %0d tx %b rx %b want 4 0 0", size_rx[0][0], bn_tx[0][0], bn_rx[0][0]);
        end
    endtask

    task automatic test_both();
        int t, b0, b1; acc_t a0, a1;
        do_reset(); fill(0, 3); fill(1, 2);
        t = cyc; pulse(1, 1, 3, 2);
        wait_acc(0, 2, 60);
        checks++;
        if (n_acc(0) !== 2) begin errors++; $display("FAIL both_acc_count: got %0d want 2", n_acc(0)); end
        a0 = get_acc(0, 0); a1 = get_acc(0, 1);
        checks++;
        if (a0.d !== 0 || a0.cyc !== t + 6 || a0.size !== 3) begin
            errors++; $display("FAIL both_first: got d %0d cyc %0d size %0d want d 0 cyc %0d size 3", a0.d, a0.cyc, a0.size, t + 6);
        end
        checks++;
        if (a1.d !== 1 || a1.cyc !== t + 12 || a1.size !== 2) begin
            errors++; $display("FAIL both_second: got d %0d cyc %0d size %0d want d 1 cyc %0d size 2", a1.d, a1.cyc, a1.size, t + 12);
        end
        b0 = wr_bad(0, 0, 3, t + 3, 1); b1 = wr_bad(0, 1, 2, t + 10, 1);
        checks++;
        if (b0 !== 0 || b1 !== 0) begin errors++; $display("FAIL both_writes: got %0d/%0d deviations want 0/0", b0, b1); end
    endtask

    task automatic test_blocked();
        int t, r, b; acc_t a;
        do_reset(); fill(0, 5); fill(1, 3);
        busy_rx_in[0] = 1'b1;
        t = cyc; pulse(1, 1, 5, 3);
        wait_acc(0, 1, 60);
        step(20);
        a = get_acc(0, 0);
        checks++;
        if (n_acc(0) !== 1 || a.d !== 1 || a.cyc !== t + 6) begin
            errors++; $display("FAIL blocked_b2a: got n %0d d %0d cyc %0d want n 1 d 1 cyc %0d", n_acc(0), a.d, a.cyc, t + 6);
        end
        b = wr_bad(0, 1, 3, t + 3, 1) + wr_bad(0, 0, 0, 0, 1);
        checks++;
        if (b !== 0 || bn_tx[0][0] !== 1'b1) begin
            errors++; $display("FAIL blocked_writes: got %0d deviations pend %b want 0 1", b, bn_tx[0][0]);
        end
        r = cyc; busy_rx_in[0] = 1'b0;
        wait_acc(0, 2, 60);
        a = get_acc(0, 1);
        checks++;
        if (a.d !== 0 || a.cyc !== r + 7 || a.size !== 5) begin
            errors++; $display("FAIL blocked_release: got d %0d cyc %0d size %0d want d 0 cyc %0d size 5", a.d, a.cyc, a.size, r + 7);
        end
        b = wr_bad(0, 0, 5, r + 2, 1);
        checks++;
        if (b !== 0) begin errors++; $display("FAIL blocked_release_writes: got %0d deviations want 0", b); end
    endtask

    task automatic test_errors();
        int r, b; acc_t a;
        do_reset();
        pulse(1, 0, 0, 0);
        checks++;
        if (ezero[0] !== 1'b1 || eovr[0] !== 1'b0 || bn_tx[0][0] !== 1'b0) begin
            errors++; $display("FAIL err_zero: got z %b o %b pend %b want 1 0 0", ezero[0], eovr[0], bn_tx[0][0]);
        end
        busy_tx_in[0] = 1'b1; fill(0, 5);
        pulse(1, 0, 5, 0);
        checks++;
        if (bn_tx[0][0] !== 1'b1 || eovr[0] !== 1'b0) begin
            errors++; $display("FAIL err_accept: got pend %b o %b want 1 0", bn_tx[0][0], eovr[0]);
        end
        pulse(1, 0, 7, 0);
        step(5);
        checks++;
        if (eovr[0] !== 1'b1 || n_acc(0) !== 0) begin
            errors++; $display("FAIL err_overrun: got o %b acc %0d want 1 0", eovr[0], n_acc(0));
        end
        r = cyc; busy_tx_in[0] = 1'b0;
        wait_acc(0, 1, 60);
        a = get_acc(0, 0);
        b = wr_bad(0, 0, 5, r + 2, 1);
        checks++;
        if (a.cyc !== r + 7 || a.size !== 5 || b !== 0 || ezero[0] !== 1'b1) begin
            errors++; $display("FAIL err_delivery: got cyc %0d size %0d dev %0d z %b want cyc %0d size 5 dev 0 z 1", a.cyc, a.size, b, ezero[0], r + 7);
        end
    endtask

    task automatic test_reset_mid();
        int t, b; acc_t a;
        do_reset(); fill(0, 10);
        t = cyc; pulse(1, 0, 10, 0);
        for (int c = 0; c < 20 && cyc < t + 7; c++) step();
        reset_high = 1'b1;
        step();
        checks++;
        if (any_out(0) !== 1'b0 || any_out(1) !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: got nonzero output want all 0");
        end
        reset_high = 1'b0;
        step(20);
        b = wr_bad(0, 0, 5, t + 3, 1);
        checks++;
        if (n_acc(0) !== 0 || n_acc(1) !== 0 || b !== 0) begin
            errors++; $display("FAIL rstmid_discard: got acc %0d/%0d dev %0d want 0/0 0", n_acc(0), n_acc(1), b);
        end
        fill(0, 2); wlog.delete();
        t = cyc; pulse(1, 0, 2, 0);
        wait_acc(0, 1, 40);
        a = get_acc(0, 0);
        b = wr_bad(0, 0, 2, t + 3, 1);
        checks++;
        if (a.cyc !== t + 5 || a.size !== 2 || b !== 0) begin
            errors++; $display("FAIL rstmid_next: got cyc %0d size %0d dev %0d want cyc %0d size 2 dev 0", a.cyc, a.size, b, t + 5);
        end
    endtask

    task automatic test_word_gap();
        int t, b; acc_t a;
        do_reset(); fill(0, 3);
        t = cyc; pulse(1, 0, 3, 0);
        wait_acc(1, 1, 60);
        a = get_acc(1, 0);
        checks++;
        if (a.cyc !== t + 10 || a.size !== 3 || a.d !== 0) begin
            errors++; $display("FAIL gap_acc: got cyc %0d size %0d want cyc %0d size 3", a.cyc, a.size, t + 10);
        end
        b = wr_bad(1, 0, 3, t + 3, 3);
        checks++;
        if (b !== 0) begin errors++; $display("FAIL gap_writes: got %0d deviations want 0", b); end
    endtask

    task automatic test_random();
        int t, pat, na, nb, nexp, first, n1, n2, g, ac, b, lg;
        acc_t a;
        do_reset();
        lg = 1;
        for (int it = 0; it < 8; it++) begin
            na = $urandom_range(1, 20); nb = $urandom_range(1, 20);
            pat = $urandom_range(1, 3);
            fill(0, na); fill(1, nb);
            wlog.delete(); alog.delete();
            t = cyc; pulse(pat[0], pat[1], na, nb);
            nexp = (pat == 3) ? 2 : 1;
            wait_acc(0, nexp, 200);
            checks++;
            if (n_acc(0) !== nexp) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", it, n_acc(0), nexp); end
            first = (pat == 3) ? 1 - lg : ((pat == 2) ? 1 : 0);
            n1 = (first == 1) ? nb : na;
            g = t + 1; ac = g + 2 + n1;
            a = get_acc(0, 0); b = wr_bad(0, first, n1, g + 2, 1);
            checks++;
            if (a.d !== first || a.cyc !== ac || a.size !== n1 || b !== 0) begin
                errors++; $display("FAIL rand%0d_first: got d %0d cyc %0d size %0d dev %0d want d %0d cyc %0d size %0d dev 0", it, a.d, a.cyc, a.size, b, first, ac, n1);
            end
            lg = first;
            if (pat == 3) begin
                n2 = (first == 1) ? na : nb;
                g = ac + 2; ac = g + 2 + n2;
                a = get_acc(0, 1); b = wr_bad(0, 1 - first, n2, g + 2, 1);
                checks++;
                if (a.d !== 1 - first || a.cyc !== ac || a.size !== n2 || b !== 0) begin
                    errors++; $display("FAIL rand%0d_second: got d %0d cyc %0d size %0d dev %0d want d %0d cyc %0d size %0d dev 0", it, a.d, a.cyc, a.size, b, 1 - first, ac, n2);
                end
                lg = 1 - first;
            end
            step(3);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_blocked();
        test_errors();
        test_reset_mid();
        test_word_gap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
